// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: controller state
// encoding, default register-index width and the NOP instruction word that
// the datapath injects when a bubble or flush is requested.
package pipe_ctrl_pkg;

  // Default register-index width (32 architectural registers)
  localparam int REG_W_DEF = 5;

  // Canonical NOP (addi x0, x0, 0) placed into IF/ID or ID/EX on flush/bubble
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // Hazard controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the instruction in ID/EX is a load
// whose destination is read by the instruction in IF/ID. Register 0 is
// hard-wired to zero, so a load targeting it never creates a dependency.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             idex_memrd,
  input  logic [REG_W-1:0] idex_rd,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  output logic             load_use
);

  logic rd_nonzero;
  logic rs_match;

  // Dependency check between the pending load and both source operands
  always_comb begin
    rd_nonzero = (idex_rd != '0);
    rs_match   = (idex_rd == ifid_rs1) || (idex_rd == ifid_rs2);
    load_use   = idex_memrd && rd_nonzero && rs_match;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a classic 5-stage pipeline. Handles
// load-use stalls, taken-branch flushes and data-memory wait states, and
// traps into a sticky error state when memory stays busy too long.
// Optional build macro HAZARD_PERF_CNT_EN adds a saturating stall-cycle
// counter on port stall_cnt_o.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             idex_memrd_i,
  input  logic [REG_W-1:0] idex_rd_i,
  input  logic [REG_W-1:0] ifid_rs1_i,
  input  logic [REG_W-1:0] ifid_rs2_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             pc_write_o,
  output logic             ifid_stall_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             back_stall_o,
  output logic             err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  // Wait counter must hold values 0..MAX_WAIT
  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  hz_state_t         state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;

  load_use_detect #(
    .REG_W (REG_W)
  ) u_load_use (
    .idex_memrd (idex_memrd_i),
    .idex_rd    (idex_rd_i),
    .ifid_rs1   (ifid_rs1_i),
    .ifid_rs2   (ifid_rs2_i),
    .load_use   (load_use)
  );

  // Control outputs decoded from state and the current hazard inputs.
  // A MEM_WAIT cycle with memory ready lets the pipeline advance at once.
  always_comb begin
    pc_write_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_bubble_o = 1'b0;
    back_stall_o  = 1'b0;
    err_o         = 1'b0;
    case (state)
      ST_IDLE: begin
        ifid_flush_o = 1'b1;
      end
      ST_RUN: begin
        if (mem_busy_i) begin
          ifid_stall_o = 1'b1;
          back_stall_o = 1'b1;
        end else if (load_use) begin
          ifid_stall_o  = 1'b1;
          idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
          pc_write_o   = 1'b1;
          ifid_flush_o = 1'b1;
        end else begin
          pc_write_o = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy_i) begin
          ifid_stall_o = 1'b1;
          back_stall_o = 1'b1;
        end else begin
          pc_write_o = 1'b1;
        end
      end
      ST_ERR: begin
        ifid_stall_o = 1'b1;
        back_stall_o = 1'b1;
        err_o        = 1'b1;
      end
      default: begin
        ifid_flush_o = 1'b1;
      end
    endcase
  end

  // State sequencing and memory wait-time supervision
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (mem_busy_i) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_ONE;
          end else if (!start_i) begin
            state <= ST_IDLE;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_busy_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            state <= ST_ERR;
          end else begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
        end
        ST_ERR: begin
          state <= ST_ERR;
        end
        default: begin
          state    <= ST_IDLE;
          wait_cnt <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic stall_cycle;

  // A stall cycle is any active-pipeline cycle in which the PC is held
  always_comb begin
    stall_cycle = !pc_write_o && ((state == ST_RUN) || (state == ST_MEM_WAIT));
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_cycle && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Expected output vectors are
// queued as each cycle of stimulus is driven and compared mid-cycle.
// Output vector bit order: {pc_write, ifid_stall, ifid_flush, idex_bubble,
// back_stall, err}.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;

  localparam logic [5:0] E_IDLE = 6'b001000;
  localparam logic [5:0] E_NORM = 6'b100000;
  localparam logic [5:0] E_LU   = 6'b010100;
  localparam logic [5:0] E_BR   = 6'b101000;
  localparam logic [5:0] E_MEM  = 6'b010010;
  localparam logic [5:0] E_ERR  = 6'b010011;

  logic             clk_i;
  logic             rst_i;
  logic             start_i;
  logic             idex_memrd_i;
  logic [REG_W-1:0] idex_rd_i;
  logic [REG_W-1:0] ifid_rs1_i;
  logic [REG_W-1:0] ifid_rs2_i;
  logic             branch_taken_i;
  logic             mem_busy_i;
  logic             pc_write_o;
  logic             ifid_stall_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             back_stall_o;
  logic             err_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o;
`endif

  pipe_hazard_ctrl #(
    .REG_W    (REG_W),
    .MAX_WAIT (15),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .idex_memrd_i   (idex_memrd_i),
    .idex_rd_i      (idex_rd_i),
    .ifid_rs1_i     (ifid_rs1_i),
    .ifid_rs2_i     (ifid_rs2_i),
    .branch_taken_i (branch_taken_i),
    .mem_busy_i     (mem_busy_i),
    .pc_write_o     (pc_write_o),
    .ifid_stall_o   (ifid_stall_o),
    .ifid_flush_o   (ifid_flush_o),
    .idex_bubble_o  (idex_bubble_o),
    .back_stall_o   (back_stall_o),
    .err_o          (err_o)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt_o)
`endif
  );

  typedef struct {
    string      tag;
    logic [5:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: sim time exceeded, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [5:0] obs_vec();
    return {pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, back_stall_o, err_o};
  endfunction

  // One clock cycle: drive on the falling edge, queue the expectation,
  // then compare the combinational outputs before the next rising edge.
  task automatic cyc(input string tag, input logic st, input logic memrd,
                     input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1,
                     input logic [REG_W-1:0] rs2, input logic br, input logic busy,
                     input logic [5:0] exp);
    sb_t e;
    @(negedge clk_i);
    start_i        = st;
    idex_memrd_i   = memrd;
    idex_rd_i      = rd;
    ifid_rs1_i     = rs1;
    ifid_rs2_i     = rs2;
    branch_taken_i = br;
    mem_busy_i     = busy;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
    #2;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, 32'(obs_vec()), 32'(e.exp));
    end
  endtask

  // Normal run cycle with no hazards
  task automatic run_norm(input string tag);
    cyc(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
  endtask

  // Memory busy cycle in RUN or MEM_WAIT
  task automatic busy_cyc(input string tag);
    cyc(tag, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_MEM);
  endtask

  // Assert reset for one cycle, release it with start low, then one IDLE
  // cycle with start high so the following cycle is RUN.
  task automatic restart();
    @(negedge clk_i);
    rst_i = 1'b0;
    cyc("rst_idle", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
    rst_i   = 1'b1;
    start_i = 1'b0;
    cyc("idle_start", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
  endtask

  initial begin
    rst_i          = 1'b0;
    start_i        = 1'b0;
    idex_memrd_i   = 1'b0;
    idex_rd_i      = '0;
    ifid_rs1_i     = '0;
    ifid_rs2_i     = '0;
    branch_taken_i = 1'b0;
    mem_busy_i     = 1'b0;

    // Reset holds IDLE outputs even with start and hazards asserted
    cyc("reset_out", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
    cyc("reset_start", 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, E_IDLE);
    check("reset_err", 32'(err_o), 32'd0);
    rst_i   = 1'b1;
    start_i = 1'b0;
    mem_busy_i = 1'b0;

    // Start: one IDLE cycle, then the PC advances
    cyc("idle_1cyc", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
    run_norm("run_first");

    // Load-use detection
    cyc("lu_rs2", 1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 1'b0, E_LU);
    run_norm("lu_release");
    cyc("lu_rs1", 1'b1, 1'b1, 5'd7, 5'd7, 5'd3, 1'b0, 1'b0, E_LU);
    cyc("rd0_no_stall", 1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
    cyc("no_load", 1'b1, 1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, E_NORM);
    cyc("no_match", 1'b1, 1'b1, 5'd5, 5'd6, 5'd4, 1'b0, 1'b0, E_NORM);
    cyc("lu_rd31", 1'b1, 1'b1, 5'd31, 5'd1, 5'd31, 1'b0, 1'b0, E_LU);

    // Load-use beats branch; branch alone flushes
    cyc("lu_beats_br", 1'b1, 1'b1, 5'd9, 5'd9, 5'd2, 1'b1, 1'b0, E_LU);
    cyc("branch", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, E_BR);
    run_norm("after_branch");
    cyc("busy_beats_lu", 1'b1, 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, E_MEM);
    cyc("busy_release0", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
    run_norm("busy_back_run");

    // Three busy cycles from a fresh start; hazards ignored in MEM_WAIT
    restart();
    busy_cyc("mem3_c1");
    cyc("mem3_c2_ign", 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, E_MEM);
    busy_cyc("mem3_c3");
    cyc("mem3_release", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_3", stall_cnt_o, 32'd3);
`endif
    run_norm("mem3_run");

    // Exactly MAX_WAIT busy cycles do not trip the error
    for (int i = 0; i < 15; i++) busy_cyc("mem15");
    cyc("mem15_release", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
    run_norm("mem15_no_err");
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_18", stall_cnt_o, 32'd18);
`endif

    // start low: returns to IDLE, but memory-busy entry wins
    cyc("stop_run", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
    cyc("stopped_idle", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
    cyc("stop_busy", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_MEM);
    cyc("stop_busy_rel", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
    cyc("stop_run2", 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_NORM);
    cyc("stopped_idle2", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);

    // Sixteen busy cycles trip the sticky error
    for (int i = 0; i < 16; i++) busy_cyc("mem16");
    cyc("err_entry", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_ERR);
    cyc("err_sticky", 1'b0, 1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0, E_ERR);
`ifdef HAZARD_PERF_CNT_EN
    check("stall_cnt_35", stall_cnt_o, 32'd35);
`endif

    // Asynchronous reset in ERR clears error without a clock edge
    rst_i = 1'b0;
    #1;
    check("async_err_clr", 32'(err_o), 32'd0);
    check("async_idle_out", 32'(obs_vec()), 32'(E_IDLE));
`ifdef HAZARD_PERF_CNT_EN
    check("async_cnt_clr", stall_cnt_o, 32'd0);
`endif
    cyc("err_reset_hold", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, E_IDLE);
    rst_i   = 1'b1;
    start_i = 1'b0;
    mem_busy_i = 1'b0;
    cyc("post_err_idle", 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, E_IDLE);
    run_norm("post_err_run");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter MAX_WAIT, default 15, maximum consecutive memory-busy cycles tolerated.
REQ-003 SHALL have parameter CNT_W, default 32, stall-counter width.
REQ-004 SHALL have ports: clk_i  in  1  clock, rising edge; the block's only clock.
REQ-005 SHALL have ports: rst_i  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: start_i  in  1  pipeline enable.
REQ-007 SHALL have ports: idex_memrd_i  in  1  ID/EX instruction is a load.
REQ-008 SHALL have ports: idex_rd_i  in  REG_W  ID/EX destination register.
REQ-009 SHALL have ports: ifid_rs1_i, ifid_rs2_i  in  REG_W each  IF/ID source registers.
REQ-010 SHALL have ports: branch_taken_i  in  1  branch resolved taken in ID.
REQ-011 SHALL have ports: mem_busy_i  in  1  data memory not ready.
REQ-012 SHALL have ports: pc_write_o  out  1  PC update enable.
REQ-013 SHALL have ports: ifid_stall_o, ifid_flush_o  out  1 each  IF/ID hold / zero.
REQ-014 SHALL have ports: idex_bubble_o  out  1  insert NOP into ID/EX.
REQ-015 SHALL have ports: back_stall_o  out  1  freeze EX/MEM and MEM/WB.
REQ-016 SHALL have ports: err_o  out  1  sticky memory timeout.
REQ-017 SHALL have ports: stall_cnt_o  out  CNT_W  stall cycles (only with macro).

Function
REQ-018 SHALL implement states IDLE, RUN, MEM_WAIT, ERR; outputs are combinational from state and current inputs.
REQ-019 IDLE: pc_write_o=0, ifid_flush_o=1, all others 0; start_i=1 moves to RUN next edge.
REQ-020 RUN, load-use = idex_memrd_i & idex_rd_i!=0 & (idex_rd_i==ifid_rs1_i | idex_rd_i==ifid_rs2_i).
REQ-021 RUN priority: mem_busy_i > load-use > branch_taken_i > normal.
REQ-022 RUN + mem_busy_i: pc_write_o=0, ifid_stall_o=1, back_stall_o=1 same cycle; move to MEM_WAIT; wait counter loads 1.
REQ-023 RUN + load-use: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1 for that cycle only; state stays RUN.
REQ-024 RUN + branch_taken_i (no load-use): pc_write_o=1, ifid_flush_o=1 for one cycle.
REQ-025 RUN normal: pc_write_o=1, all others 0.
REQ-026 MEM_WAIT: same outputs as REQ-022; load-use and branch ignored; mem_busy_i=0 returns to RUN next edge.
REQ-027 MEM_WAIT: counter increments each busy cycle; busy with counter==MAX_WAIT moves to ERR.
REQ-028 ERR: pc_write_o=0, ifid_stall_o=1, back_stall_o=1, err_o=1; exit only by reset.
REQ-029 start_i=0 in RUN returns to IDLE next edge, lowest priority behind MEM_WAIT entry.
REQ-030 idex_rd_i==0 never causes a stall.

Reset
REQ-031 rst_i low SHALL asynchronously force IDLE, wait counter 0, err_o 0, stall_cnt_o 0, including mid-MEM_WAIT.
REQ-032 During reset, outputs SHALL equal IDLE values.

Configuration
REQ-033 With HAZARD_PERF_CNT_EN defined, stall_cnt_o SHALL increment on each cycle with pc_write_o=0 in RUN or MEM_WAIT, saturating at all-ones.
REQ-034 Without HAZARD_PERF_CNT_EN, port and counter SHALL be absent.

Structure
REQ-035 Package pipe_ctrl_pkg SHALL hold state enum, REG_W default and NOP encoding constant.
REQ-036 Load-use comparison SHALL be a sub-module load_use_detect; the FSM stays in the top.

Verification
REQ-037 Reset, start_i=1 -> IDLE one cycle, then pc_write_o=1.
REQ-038 memrd=1, rd=5, rs2=5 -> one cycle pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1; rd=0, rs1=0 -> no stall.
REQ-039 Load-use plus branch_taken_i same cycle -> stall only, ifid_flush_o=0.
REQ-040 mem_busy_i high 3 cycles -> back_stall_o high 3 cycles, RUN on 4th; stall_cnt_o=3.
REQ-041 mem_busy_i high 16 cycles with MAX_WAIT=15 -> err_o=1 held; rst_i low mid-ERR -> err_o=0 immediately.
